// File: rtl/spi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the spi_ctrl front-end: register offsets (addr[3:2]),
// CTRL / STATUS / IRQ_EN bit positions, the CTRL reset value and the
// transaction sequencer state encoding.
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

   // Register select values taken from addr[3:2]
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_IRQ_EN = 2'd3;

   // CTRL bit positions
   localparam int CTRL_RUN    = 0;
   localparam int CTRL_TURNON = 1;
   localparam int CTRL_CPOL   = 2;
   localparam int CTRL_CPHA   = 3;
   localparam int CTRL_ORDER  = 4;
   localparam int CTRL_SEL_LO = 5;
   localparam int CTRL_SEL_HI = 6;
   localparam int CTRL_PRE_LO = 8;
   localparam int CTRL_PRE_HI = 31;

   // STATUS bit positions
   localparam int ST_BUSY     = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_OVF   = 5;

   // IRQ_EN bit positions
   localparam int IE_TX_EMPTY    = 0;
   localparam int IE_RX_NONEMPTY = 1;
   localparam int IE_OVF         = 2;

   // CTRL comes out of reset with only cpol set
   localparam logic [31:0] CTRL_RESET = 32'h0000_0004;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      CAPTURE   = 3'd4
   } state_t;

endpackage

// File: rtl/spi_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with full/empty flags. A push and a pop in the same cycle
// both take effect (count unchanged), including when the FIFO is full.
// Pushes into a full FIFO without a pop, and pops from an empty FIFO, are
// ignored.
// Ports:
//   i_clk, i_nrst   clock, asynchronous active-low reset
//   i_push, i_data  write strobe and data
//   i_pop           read strobe (advances the head)
//   o_head          current head entry (valid when !o_empty)
//   o_full, o_empty occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo
   import spi_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_doPush;
   logic             w_doPop;

   // Pointers carry one extra wrap bit so full and empty can be told apart
   assign o_empty  = (r_wrPtr == r_rdPtr);
   assign o_full   = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);
   assign o_head   = r_mem[r_rdPtr[AW-1:0]];

   // Pointer update; each pointer moves independently
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Storage is not reset; the empty flag guards every read of it
   always_ff @(posedge i_clk) begin
      if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/spi_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ctrl
// Memory-mapped front-end for the `spi` protocol controller. Outgoing words
// queue in a TX FIFO, received bytes in an RX FIFO. One `spi` transaction is
// sequenced per TX entry through an enable/busy handshake, using a shadow copy
// of CTRL latched at the start of each transaction.
// Optional feature macro: SPI_CTRL_IRQ_EN (implements IRQ_EN and o_irq;
// without it o_irq is 0 and IRQ_EN reads 0).
// Ports:
//   i_clk, i_nrst            core clock, asynchronous active-low reset
//   i_wr_en, i_rd_en         one-cycle bus strobes
//   i_addr[3:0], i_wdata     byte offset (addr[3:2] selects) and write data
//   o_rdata                  registered read data, valid the cycle after i_rd_en
//   o_irq                    level interrupt
//   o_spi_*                  controls to `spi` (turnon, enable, prescale, din,
//                            select, order, cpha, cpol)
//   i_spi_rco, i_spi_dat     status (bit0 busy) and received byte from `spi`
// Register map: 0x0 DATA, 0x4 CTRL, 0x8 STATUS (W1C on 5:4), 0xC IRQ_EN.
// ---------------------------------------------------------------------------
module spi_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_wr_en,
   input  logic        i_rd_en,
   input  logic [3:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_irq,
   output logic        o_spi_turnon,
   output logic        o_spi_enable,
   output logic [23:0] o_spi_prescale,
   output logic [31:0] o_spi_din,
   output logic [1:0]  o_spi_select,
   output logic        o_spi_order,
   output logic        o_spi_cpha,
   output logic        o_spi_cpol,
   input  logic [31:0] i_spi_rco,
   input  logic [31:0] i_spi_dat
);

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_ctrl;
   logic        r_txOvf;
   logic        r_rxOvf;
   logic        r_rcoBusy;
   logic [31:0] r_rdata;
   logic        r_spiEnable;
   logic [23:0] r_spiPrescale;
   logic [31:0] r_spiDin;
   logic [1:0]  r_spiSelect;
   logic        r_spiOrder;
   logic        r_spiCpha;
   logic        r_spiCpol;

   logic        w_wrData;
   logic        w_wrCtrl;
   logic        w_wrStatus;
   logic        w_rdData;
   logic        w_txFull;
   logic        w_txEmpty;
   logic [31:0] w_txHead;
   logic        w_rxFull;
   logic        w_rxEmpty;
   logic [7:0]  w_rxHead;
   logic        w_rxPopDo;
   logic        w_start;
   logic        w_load;
   logic        w_txPop;
   logic        w_rxPush;
   logic        w_enableNext;
   logic        w_txOvfSet;
   logic        w_rxOvfSet;
   logic        w_xferBusy;
   logic [31:0] w_status;
   logic [31:0] w_irqEnRead;
   logic [31:0] w_readValue;
   logic        w_unused;

   // Only the busy bit of rco, the low byte of dat and addr[3:2] matter here
   assign w_unused = &{1'b0, i_addr[1:0], i_spi_rco[31:1], i_spi_dat[31:8]};

   assign w_wrData   = i_wr_en && (i_addr[3:2] == REG_DATA);
   assign w_wrCtrl   = i_wr_en && (i_addr[3:2] == REG_CTRL);
   assign w_wrStatus = i_wr_en && (i_addr[3:2] == REG_STATUS);
   assign w_rdData   = i_rd_en && (i_addr[3:2] == REG_DATA);
   assign w_rxPopDo  = w_rdData && !w_rxEmpty;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_txFifo (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_push  (w_wrData),
      .i_pop   (w_txPop),
      .i_data  (i_wdata),
      .o_head  (w_txHead),
      .o_full  (w_txFull),
      .o_empty (w_txEmpty)
   );

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_rxFifo (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_push  (w_rxPush),
      .i_pop   (w_rdData),
      .i_data  (i_spi_dat[7:0]),
      .o_head  (w_rxHead),
      .o_full  (w_rxFull),
      .o_empty (w_rxEmpty)
   );

   // CTRL register; turnon is forwarded directly, the rest via the shadows
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_ctrl <= CTRL_RESET;
      else if (w_wrCtrl) r_ctrl <= i_wdata;
   end

   assign o_spi_turnon = r_ctrl[CTRL_TURNON];

   // Busy from `spi` goes through one register before the FSM looks at it
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_rcoBusy <= 1'b0;
      else r_rcoBusy <= i_spi_rco[0];
   end

   // State register
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_state <= IDLE;
      else r_state <= w_nextState;
   end

   assign w_start = r_ctrl[CTRL_TURNON] && r_ctrl[CTRL_RUN] && !w_txEmpty;

   // Next state and per-state strobes; clearing turnon aborts any transaction
   // without touching either FIFO
   always_comb begin
      w_nextState  = r_state;
      w_load       = 1'b0;
      w_txPop      = 1'b0;
      w_rxPush     = 1'b0;
      w_enableNext = 1'b0;
      if ((r_state != IDLE) && !r_ctrl[CTRL_TURNON]) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) w_nextState = LOAD;
            end
            LOAD: begin
               w_load       = 1'b1;
               w_enableNext = 1'b1;
               w_nextState  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (r_rcoBusy) w_nextState = WAIT_DONE;
               else w_enableNext = 1'b1;
            end
            WAIT_DONE: begin
               if (!r_rcoBusy) w_nextState = CAPTURE;
            end
            CAPTURE: begin
               w_txPop     = 1'b1;
               w_rxPush    = 1'b1;
               w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Shadow copies of the transfer configuration, refreshed only in LOAD
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_spiEnable   <= 1'b0;
         r_spiPrescale <= '0;
         r_spiDin      <= '0;
         r_spiSelect   <= '0;
         r_spiOrder    <= 1'b0;
         r_spiCpha     <= 1'b0;
         r_spiCpol     <= 1'b1;
      end else begin
         r_spiEnable <= w_enableNext;
         if (w_load) begin
            r_spiPrescale <= r_ctrl[CTRL_PRE_HI:CTRL_PRE_LO];
            r_spiDin      <= w_txHead;
            r_spiSelect   <= r_ctrl[CTRL_SEL_HI:CTRL_SEL_LO];
            r_spiOrder    <= r_ctrl[CTRL_ORDER];
            r_spiCpha     <= r_ctrl[CTRL_CPHA];
            r_spiCpol     <= r_ctrl[CTRL_CPOL];
         end
      end
   end

   assign o_spi_enable   = r_spiEnable;
   assign o_spi_prescale = r_spiPrescale;
   assign o_spi_din      = r_spiDin;
   assign o_spi_select   = r_spiSelect;
   assign o_spi_order    = r_spiOrder;
   assign o_spi_cpha     = r_spiCpha;
   assign o_spi_cpol     = r_spiCpol;

   // A word is dropped only when TX is full and nothing leaves it this cycle;
   // the same applies to a received byte and RX
   assign w_txOvfSet = w_wrData && w_txFull && !w_txPop;
   assign w_rxOvfSet = w_rxPush && w_rxFull && !w_rxPopDo;

   // Sticky overflow flags; a new overflow wins over a same-cycle clear
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_txOvf <= 1'b0;
         r_rxOvf <= 1'b0;
      end else begin
         if (w_txOvfSet) r_txOvf <= 1'b1;
         else if (w_wrStatus && i_wdata[ST_TX_OVF]) r_txOvf <= 1'b0;
         if (w_rxOvfSet) r_rxOvf <= 1'b1;
         else if (w_wrStatus && i_wdata[ST_RX_OVF]) r_rxOvf <= 1'b0;
      end
   end

   assign w_xferBusy = (r_state != IDLE);
   assign w_status   = {26'd0, r_rxOvf, r_txOvf, w_rxEmpty, w_rxFull, w_txEmpty, w_xferBusy};

`ifdef SPI_CTRL_IRQ_EN
   logic [2:0] r_irqEn;
   logic       r_irq;
   logic       w_irqCond;

   // Interrupt enables
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_irqEn <= '0;
      else if (i_wr_en && (i_addr[3:2] == REG_IRQ_EN)) r_irqEn <= i_wdata[2:0];
   end

   assign w_irqCond = (w_txEmpty && r_irqEn[IE_TX_EMPTY])
                    | (!w_rxEmpty && r_irqEn[IE_RX_NONEMPTY])
                    | ((r_txOvf || r_rxOvf) && r_irqEn[IE_OVF]);

   // The interrupt line is the registered condition, so it trails by a cycle
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_irq <= 1'b0;
      else r_irq <= w_irqCond;
   end

   assign o_irq       = r_irq;
   assign w_irqEnRead = {29'd0, r_irqEn};
`else
   assign o_irq       = 1'b0;
   assign w_irqEnRead = 32'd0;
`endif

   // Read mux; an empty RX reads as zero
   always_comb begin
      w_readValue = 32'd0;
      case (i_addr[3:2])
         REG_DATA:   w_readValue = w_rxEmpty ? 32'd0 : {24'd0, w_rxHead};
         REG_CTRL:   w_readValue = r_ctrl;
         REG_STATUS: w_readValue = w_status;
         REG_IRQ_EN: w_readValue = w_irqEnRead;
         default:    w_readValue = 32'd0;
      endcase
   end

   // Read data register; holds its value between reads
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_rdata <= '0;
      else if (i_rd_en) r_rdata <= w_readValue;
   end

   assign o_rdata = r_rdata;

endmodule

// File: tb/tb_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ctrl
// Directed bench for spi_ctrl. Bus reads and expected `spi` din words are
// queued when issued; a monitor compares them as the DUT presents rdata or
// raises spi_enable. A simple `spi` model answers each transaction with
// din[7:0] ^ 0x66 after a programmable busy time.
// ---------------------------------------------------------------------------
module tb_spi_ctrl;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        wrEn = 1'b0;
   logic        rdEn = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;
   logic        spiTurnon;
   logic        spiEnable;
   logic [23:0] spiPrescale;
   logic [31:0] spiDin;
   logic [1:0]  spiSelect;
   logic        spiOrder;
   logic        spiCpha;
   logic        spiCpol;
   logic [31:0] spiRco;
   logic [31:0] spiDat;

   int checks = 0;
   int errors = 0;
   int busyLen = 5;

   logic [31:0] expReadVal [$];
   string       expReadName [$];
   logic [31:0] expDin [$];
   logic        readPending = 1'b0;
   logic        prevEnable = 1'b0;

   localparam logic [3:0] A_DATA   = 4'h0;
   localparam logic [3:0] A_CTRL   = 4'h4;
   localparam logic [3:0] A_STATUS = 4'h8;
   localparam logic [3:0] A_IRQEN  = 4'hC;

   spi_ctrl #(.FIFO_DEPTH(4)) dut (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .i_wr_en        (wrEn),
      .i_rd_en        (rdEn),
      .i_addr         (addr),
      .i_wdata        (wdata),
      .o_rdata        (rdata),
      .o_irq          (irq),
      .o_spi_turnon   (spiTurnon),
      .o_spi_enable   (spiEnable),
      .o_spi_prescale (spiPrescale),
      .o_spi_din      (spiDin),
      .o_spi_select   (spiSelect),
      .o_spi_order    (spiOrder),
      .o_spi_cpha     (spiCpha),
      .o_spi_cpol     (spiCpol),
      .i_spi_rco      (spiRco),
      .i_spi_dat      (spiDat)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Single-cycle bus write
   task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
      wrEn  = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      wrEn = 1'b0;
   endtask

   // Single-cycle bus read; the monitor checks rdata one cycle later
   task automatic expectRead(input logic [3:0] a, input logic [31:0] expected, input string name);
      expReadVal.push_back(expected);
      expReadName.push_back(name);
      rdEn = 1'b1;
      addr = a;
      @(posedge clk);
      #1;
      rdEn = 1'b0;
   endtask

   // Wait for the spi model to report busy, with a bounded budget
   task automatic waitBusy(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #2;
         if (spiRco[0]) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s actual=timeout expected=busy", name);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rdata"},    rdata,       32'd0);
      checkOutput({tag, "_enable"},   spiEnable,   32'd0);
      checkOutput({tag, "_turnon"},   spiTurnon,   32'd0);
      checkOutput({tag, "_din"},      spiDin,      32'd0);
      checkOutput({tag, "_prescale"}, spiPrescale, 32'd0);
      checkOutput({tag, "_select"},   spiSelect,   32'd0);
      checkOutput({tag, "_order"},    spiOrder,    32'd0);
      checkOutput({tag, "_cpha"},     spiCpha,     32'd0);
      checkOutput({tag, "_cpol"},     spiCpol,     32'd1);
      checkOutput({tag, "_irq"},      irq,         32'd0);
   endtask

   // spi model: busy two cycles after enable, then done with the echo byte
   initial begin
      logic [31:0] latched;
      spiRco = 32'd0;
      spiDat = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (spiEnable && !spiRco[0]) begin
            latched = spiDin;
            step(2);
            spiRco = 32'h1;
            step(busyLen);
            spiDat = {24'd0, latched[7:0] ^ 8'h66};
            spiRco = 32'h2;
         end
      end
   end

   always @(posedge clk) readPending <= rdEn;

   // Monitor: rdata after each read, din at each rising spi_enable
   always @(negedge clk) begin
      if (readPending) begin
         if (expReadVal.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRead actual=0x%08h expected=none", rdata);
         end else begin
            checkOutput(expReadName.pop_front(), rdata, expReadVal.pop_front());
         end
      end
      if (spiEnable && !prevEnable) begin
         if (expDin.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedXfer actual=0x%08h expected=none", spiDin);
         end else begin
            checkOutput("spiDin", spiDin, expDin.pop_front());
         end
      end
      prevEnable = spiEnable;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Power-on reset
      #1 nrst = 1'b0;
      #2;
      checkResetOutputs("por");
      step(3);
      nrst = 1'b1;
      step(1);
      expectRead(A_STATUS, 32'h0000_000A, "statusReset");
      expectRead(A_CTRL,   32'h0000_0004, "ctrlReset");
      expectRead(A_DATA,   32'h0000_0000, "rxEmptyRead");

      // Single transaction with echo 0x3C
      applyStimulus(A_CTRL, 32'h0000_000B);
      expDin.push_back(32'h0000_A55A);
      applyStimulus(A_DATA, 32'h0000_A55A);
      waitBusy("busyFirst");
      step(3);
      checkOutput("enableDropped", spiEnable, 32'd0);
      expectRead(A_STATUS, 32'h0000_0009, "statusMidXfer");
      applyStimulus(A_CTRL, 32'h0000_FF0F);
      step(20);
      checkOutput("shadowCpol", spiCpol, 32'd0);
      checkOutput("shadowCpha", spiCpha, 32'd1);
      checkOutput("shadowPrescale", spiPrescale, 32'd0);
      expectRead(A_STATUS, 32'h0000_0002, "statusRxHeld");
      expectRead(A_DATA,   32'h0000_003C, "rxEcho");
      expectRead(A_STATUS, 32'h0000_000A, "statusAfterPop");
      expectRead(A_CTRL,   32'h0000_FF0F, "ctrlReadback");

      // TX overflow with run=0, then four ordered transactions
      applyStimulus(A_CTRL, 32'h0000_000A);
      applyStimulus(A_DATA, 32'h1111_1101);
      expectRead(A_STATUS, 32'h0000_0008, "txNotEmptyNextCycle");
      applyStimulus(A_DATA, 32'h2222_2202);
      applyStimulus(A_DATA, 32'h3333_3303);
      applyStimulus(A_DATA, 32'h4444_4404);
      applyStimulus(A_DATA, 32'h5555_5505);
      expectRead(A_STATUS, 32'h0000_0018, "statusTxOvf");
      expDin.push_back(32'h1111_1101);
      expDin.push_back(32'h2222_2202);
      expDin.push_back(32'h3333_3303);
      expDin.push_back(32'h4444_4404);
      applyStimulus(A_CTRL, 32'h0000_347B);
      step(120);
      checkOutput("shadowPrescale2", spiPrescale, 32'h34);
      checkOutput("shadowSelect", spiSelect, 32'd3);
      checkOutput("shadowOrder", spiOrder, 32'd1);
      expectRead(A_STATUS, 32'h0000_0016, "statusRxFull");

      // Fifth byte into a full RX
      expDin.push_back(32'h6666_6606);
      applyStimulus(A_DATA, 32'h6666_6606);
      step(40);
      expectRead(A_STATUS, 32'h0000_0036, "statusRxOvf");
      expectRead(A_DATA, 32'h0000_0067, "rx0");
      expectRead(A_DATA, 32'h0000_0064, "rx1");
      expectRead(A_DATA, 32'h0000_0065, "rx2");
      expectRead(A_DATA, 32'h0000_0062, "rx3");
      expectRead(A_STATUS, 32'h0000_003A, "statusDrained");
      applyStimulus(A_STATUS, 32'h0000_0030);
      expectRead(A_STATUS, 32'h0000_000A, "statusW1c");

      // turnon cleared during WAIT_DONE aborts without popping
      busyLen = 40;
      applyStimulus(A_CTRL, 32'h0000_000B);
      expDin.push_back(32'h7777_7707);
      applyStimulus(A_DATA, 32'h7777_7707);
      waitBusy("busyAbort");
      step(4);
      applyStimulus(A_CTRL, 32'h0000_0008);
      step(1);
      expectRead(A_STATUS, 32'h0000_0008, "statusAbort");
      checkOutput("abortEnable", spiEnable, 32'd0);
      checkOutput("abortTurnon", spiTurnon, 32'd0);
      step(50);
      busyLen = 5;
      expDin.push_back(32'h7777_7707);
      applyStimulus(A_CTRL, 32'h0000_000B);
      step(30);
      expectRead(A_DATA, 32'h0000_0061, "rxAfterRetry");
      expectRead(A_STATUS, 32'h0000_000A, "statusAfterRetry");

`ifdef SPI_CTRL_IRQ_EN
      applyStimulus(A_IRQEN, 32'h0000_0002);
      expectRead(A_IRQEN, 32'h0000_0002, "irqEnRead");
      step(1);
      checkOutput("irqIdle", irq, 32'd0);
      expDin.push_back(32'h0000_A55A);
      applyStimulus(A_DATA, 32'h0000_A55A);
      step(30);
      checkOutput("irqRxByte", irq, 32'd1);
      expectRead(A_DATA, 32'h0000_003C, "rxIrqByte");
      checkOutput("irqPopEdge", irq, 32'd1);
      step(1);
      checkOutput("irqCleared", irq, 32'd0);
`else
      applyStimulus(A_IRQEN, 32'h0000_0007);
      expectRead(A_IRQEN, 32'h0000_0000, "irqEnAbsent");
      checkOutput("irqTied", irq, 32'd0);
`endif

      // Reset asserted while the sequencer is in LOAD
      applyStimulus(A_DATA, 32'h0000_BEEF);
      step(1);
      nrst = 1'b0;
      #1;
      checkResetOutputs("midLoad");
      step(2);
      nrst = 1'b1;
      step(1);
      expectRead(A_STATUS, 32'h0000_000A, "statusAfterReset");
      expectRead(A_CTRL,   32'h0000_0004, "ctrlAfterReset");
      step(3);

      checkOutput("readQueueDrained", expReadVal.size(), 32'd0);
      checkOutput("dinQueueDrained", expDin.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

Memory-mapped front-end that sits between the core's load/store bus and the `spi` protocol controller. It buffers outgoing words in a TX FIFO and received bytes in an RX FIFO. It latches the transfer configuration and sequences one `spi` transaction per TX entry through an enable/busy handshake. It also reports status and an optional interrupt back to the core.

## Interface
- FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.
- clk  in  1  core clock (50 MHz), same clock that drives `spi`.
- nrst  in  1  asynchronous reset, active-low.
- wr_en  in  1  bus write strobe, one cycle.
- rd_en  in  1  bus read strobe, one cycle.
- addr  in  4  byte offset; addr[3:2] selects the register.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- irq  out  1  level interrupt; present only with the IRQ macro.
- spi_turnon, spi_enable  out  1 each  to `spi` turnon/enable.
- spi_prescale  out  24  to `spi` prescale.
- spi_din  out  32  to `spi` din.
- spi_select  out  2  to `spi` select.
- spi_order, spi_cpha, spi_cpol  out  1 each  to `spi`.
- spi_rco  in  32  from `spi`; bit0 busy, bit1 done.
- spi_dat  in  32  from `spi`; bits [7:0] received byte.

## Operation
- Register map:
  - 0x0 DATA: a write pushes wdata into TX; a read pops RX[7:0], zero-extended.
  - 0x4 CTRL: prescale[31:8], select[6:5], order[4], cpha[3], cpol[2], turnon[1], run[0].
  - 0x8 STATUS: rx_ovf[5], tx_ovf[4], rx_empty[3], rx_full[2], tx_empty[1], xfer_busy[0]; write-1-to-clear on bits 5:4.
  - 0xC IRQ_EN: tx_empty_ie[0], rx_nonempty_ie[1], ovf_ie[2].
- Write to DATA when TX is full: word dropped, tx_ovf set. Read of DATA when RX is empty: returns 0, no pop.
- spi_turnon follows CTRL.turnon combinationally from its register.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, CAPTURE.
  - IDLE→LOAD when turnon & run & !tx_empty.
  - LOAD: latch prescale/select/order/cpha/cpol into shadow outputs, drive spi_din from the TX head, assert spi_enable; go to WAIT_BUSY.
  - WAIT_BUSY: hold spi_enable until spi_rco[0]=1; then deassert it and go to WAIT_DONE.
  - WAIT_DONE: wait for spi_rco[0]=0; go to CAPTURE.
  - CAPTURE: pop TX; push spi_dat[7:0] to RX, or set rx_ovf and drop the byte if RX is full; go to IDLE.
- CTRL writes while not IDLE affect only the next transaction (shadow outputs). The exception is turnon.
- turnon=0 in any non-IDLE state: abort to IDLE next cycle, spi_enable=0, TX head not popped, nothing pushed.
- xfer_busy = state≠IDLE.
- Simultaneous TX push and pop: both happen, count unchanged. Same rule for RX.

## Timing
- Reset values: rdata=0, spi_enable=0, spi_turnon=0, spi_din=0, spi_prescale=0, spi_select=0, spi_order=0, spi_cpha=0, spi_cpol=1, irq=0. All FIFOs empty, all flags 0, CTRL=0x00000004 (cpol=1), state IDLE.
- rdata valid on the cycle after rd_en; the pop takes effect on that same edge.
- spi_rco is sampled through one register. WAIT_BUSY therefore lasts at most 4(prescale+1)+1 clk cycles.
- IDLE→LOAD takes 1 cycle; back-to-back transactions have 2 idle clk cycles minimum (CAPTURE, IDLE).
- Write to DATA is visible in tx_empty on the next cycle.

## Configuration
- SPI_CTRL_IRQ_EN defined: IRQ_EN register implemented. The interrupt condition is irq = (tx_empty&ie0) | (!rx_empty&ie1) | ((tx_ovf|rx_ovf)&ie2), and irq is driven by a register holding that condition.
- Undefined: irq tied to 0, IRQ_EN reads 0, writes to IRQ_EN are ignored.

## Structure
- Shared package `spi_ctrl_pkg`: register offsets, CTRL/STATUS bit positions, FSM state encoding, CTRL reset value.
- One sub-module `sync_fifo` (parameter WIDTH, DEPTH), instantiated twice: TX at 32 bits, RX at 8 bits. It provides full/empty and same-cycle push+pop.

## Test plan
- Reset mid-LOAD (nrst low) → all outputs at their reset values immediately; FIFOs empty after release.
- CTRL=0x0000000B, write DATA 0x0000A55A, `spi` model echoes 0x3C → spi_enable high until busy is seen, RX holds 0x3C, STATUS=0x0A.
- Five DATA writes with FIFO_DEPTH=4 and run=0 → tx_ovf=1, four entries kept; set run → four transactions, in order.
- RX filled with four bytes, fifth transaction completes → rx_ovf=1, RX contents unchanged.
- turnon cleared during WAIT_DONE → state IDLE next cycle, TX count unchanged, RX unchanged.
- With SPI_CTRL_IRQ_EN and IRQ_EN=0x2: first byte received → irq=1; read DATA → irq=0 one cycle later.
